// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying PC and the rd write-back bundle, with a valid/ready handshake.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and make in_ready_o a pure register output.
module pipe_stage_reg #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADDR_W-1:0]     in_pc_i,
    input  logic                  in_rd_wr_en_i,
    input  logic [REG_ADDR_W-1:0] in_rd_addr_i,
    input  logic [DATA_W-1:0]     in_rd_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_W-1:0]     out_pc_o,
    output logic                  out_rd_wr_en_o,
    output logic [REG_ADDR_W-1:0] out_rd_addr_o,
    output logic [DATA_W-1:0]     out_rd_data_o,
    output logic [1:0]            occupancy_o
);

    logic                  main_valid;
    logic [ADDR_W-1:0]     main_pc;
    logic                  main_wr_en;
    logic [REG_ADDR_W-1:0] main_addr;
    logic [DATA_W-1:0]     main_data;

    logic in_xfer;
    logic out_xfer;
    logic main_free;

    assign out_xfer  = main_valid && out_ready_i;
    assign main_free = !main_valid || out_ready_i;
    assign in_xfer   = in_valid_i && in_ready_o;

`ifdef PIPE_STAGE_SKID_EN
    logic                  skid_valid;
    logic [ADDR_W-1:0]     skid_pc;
    logic                  skid_wr_en;
    logic [REG_ADDR_W-1:0] skid_addr;
    logic [DATA_W-1:0]     skid_data;

    assign in_ready_o  = !skid_valid;
    assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

    // Skid only fills while main is stalled, so a valid skid always implies a valid main.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_wr_en <= 1'b0;
            main_addr  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_wr_en <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_wr_en <= 1'b0;
            main_addr  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_wr_en <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_pc    <= skid_pc;
                main_wr_en <= skid_wr_en;
                main_addr  <= skid_addr;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_valid <= 1'b1;
                main_pc    <= in_pc_i;
                main_wr_en <= in_rd_wr_en_i;
                main_addr  <= in_rd_addr_i;
                main_data  <= in_rd_data_i;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_pc    <= in_pc_i;
            skid_wr_en <= in_rd_wr_en_i;
            skid_addr  <= in_rd_addr_i;
            skid_data  <= in_rd_data_i;
        end
    end
`else
    assign in_ready_o  = main_free;
    assign occupancy_o = {1'b0, main_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_wr_en <= 1'b0;
            main_addr  <= '0;
            main_data  <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            main_pc    <= '0;
            main_wr_en <= 1'b0;
            main_addr  <= '0;
            main_data  <= '0;
        end else if (in_xfer) begin
            main_valid <= 1'b1;
            main_pc    <= in_pc_i;
            main_wr_en <= in_rd_wr_en_i;
            main_addr  <= in_rd_addr_i;
            main_data  <= in_rd_data_i;
        end else if (out_xfer) begin
            main_valid <= 1'b0;
        end
    end
`endif

    // Payload fields stay stale when empty; only the write enable is qualified.
    assign out_valid_o    = main_valid;
    assign out_pc_o       = main_pc;
    assign out_rd_wr_en_o = main_valid && main_wr_en;
    assign out_rd_addr_o  = main_addr;
    assign out_rd_data_o  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed table, stall/flush/reset sequences and
// randomized traffic compared against a capacity-bounded queue model.
module tb_pipe_stage_reg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              wr;
        logic [RA_W-1:0]   addr;
        logic [DATA_W-1:0] data;
    } payload_t;

    typedef struct {
        logic     flush;
        logic     vld;
        payload_t p;
        logic     ordy;
        logic     exp_valid;
        payload_t exp_p;
        logic     exp_wr;
        int       exp_occ;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [ADDR_W-1:0] in_pc_i;
    logic              in_rd_wr_en_i;
    logic [RA_W-1:0]   in_rd_addr_i;
    logic [DATA_W-1:0] in_rd_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [ADDR_W-1:0] out_pc_o;
    logic              out_rd_wr_en_o;
    logic [RA_W-1:0]   out_rd_addr_o;
    logic [DATA_W-1:0] out_rd_data_o;
    logic [1:0]        occupancy_o;

    pipe_stage_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_ADDR_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
        .in_rd_wr_en_i(in_rd_wr_en_i), .in_rd_addr_i(in_rd_addr_i), .in_rd_data_i(in_rd_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
        .out_rd_wr_en_o(out_rd_wr_en_o), .out_rd_addr_o(out_rd_addr_o),
        .out_rd_data_o(out_rd_data_o), .occupancy_o(occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    payload_t q[$];
    payload_t last_shown;
    logic     seen_valid;
    logic [ADDR_W-1:0] seen_pc;
    logic     accepted;
    logic     saw_300;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        last_shown = '0;
    endtask

    // Drive one cycle of inputs, compare against the model before the edge, advance the model.
    task automatic tick(input logic fl, input logic vld, input payload_t p, input logic ordy);
        payload_t shown;
        logic exp_rdy;
        logic in_x;
        logic out_x;
        flush_i       = fl;
        in_valid_i    = vld;
        in_pc_i       = p.pc;
        in_rd_wr_en_i = p.wr;
        in_rd_addr_i  = p.addr;
        in_rd_data_i  = p.data;
        out_ready_i   = ordy;
        #1;
        shown   = (q.size() > 0) ? q[0] : last_shown;
        exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || ordy);
        chk("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
        chk("out_pc", 64'(out_pc_o), 64'(shown.pc));
        chk("out_wr_en", 64'(out_rd_wr_en_o), 64'((q.size() > 0) && shown.wr));
        chk("out_addr", 64'(out_rd_addr_o), 64'(shown.addr));
        chk("out_data", 64'(out_rd_data_o), 64'(shown.data));
        chk("occupancy", 64'(occupancy_o), 64'(q.size()));
        chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
        seen_valid = out_valid_o;
        seen_pc    = out_pc_o;
        if (out_valid_o && out_pc_o == 32'h300) saw_300 = 1'b1;
        in_x  = vld && exp_rdy;
        out_x = (q.size() > 0) && ordy;
        accepted = in_x;
        if (fl) begin
            model_reset();
        end else begin
            if (out_x) last_shown = q.pop_front();
            if (in_x) q.push_back(p);
        end
        @(negedge clk);
    endtask

    function automatic payload_t mk(input logic [31:0] pc, input logic wr,
                                    input logic [4:0] a, input logic [31:0] d);
        payload_t r;
        r.pc = pc; r.wr = wr; r.addr = a; r.data = d;
        return r;
    endfunction

    vec_t vecs[6];
    payload_t zp;
    payload_t rp;
    int got[$];
    int guard;

    initial begin
        zp = '0;
        saw_300 = 1'b0;
        vecs[0] = '{1'b0, 1'b1, mk(32'h100, 1, 5, 32'hDEADBEEF), 1'b1, 1'b1, mk(32'h100, 1, 5, 32'hDEADBEEF), 1'b1, 1};
        vecs[1] = '{1'b0, 1'b1, mk(32'h400, 0, 7, 32'h1234), 1'b1, 1'b1, mk(32'h400, 0, 7, 32'h1234), 1'b0, 1};
        vecs[2] = '{1'b0, 1'b0, zp, 1'b1, 1'b0, mk(32'h400, 0, 7, 32'h1234), 1'b0, 0};
        vecs[3] = '{1'b0, 1'b1, mk(32'h500, 1, 3, 32'h55), 1'b0, 1'b1, mk(32'h500, 1, 3, 32'h55), 1'b1, 1};
        vecs[4] = '{1'b1, 1'b1, mk(32'h300, 1, 9, 32'h99), 1'b1, 1'b0, zp, 1'b0, 0};
        vecs[5] = '{1'b0, 1'b0, zp, 1'b1, 1'b0, zp, 1'b0, 0};

        rst_n = 1'b0; flush_i = 0; in_valid_i = 0; in_pc_i = 0; in_rd_wr_en_i = 0;
        in_rd_addr_i = 0; in_rd_data_i = 0; out_ready_i = 0;
        model_reset();
        #3;
        chk("rst_valid", 64'(out_valid_o), 0);
        chk("rst_wr_en", 64'(out_rd_wr_en_o), 0);
        chk("rst_pc", 64'(out_pc_o), 0);
        chk("rst_occ", 64'(occupancy_o), 0);
        chk("rst_in_ready", 64'(in_ready_o), 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tick(vecs[i].flush, vecs[i].vld, vecs[i].p, vecs[i].ordy);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid_o), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_pc", i), 64'(out_pc_o), 64'(vecs[i].exp_p.pc));
            chk($sformatf("vec%0d_wr_en", i), 64'(out_rd_wr_en_o), 64'(vecs[i].exp_wr));
            chk($sformatf("vec%0d_addr", i), 64'(out_rd_addr_o), 64'(vecs[i].exp_p.addr));
            chk($sformatf("vec%0d_data", i), 64'(out_rd_data_o), 64'(vecs[i].exp_p.data));
            chk($sformatf("vec%0d_occ", i), 64'(occupancy_o), 64'(vecs[i].exp_occ));
        end

        // Back-to-back stream: one output per cycle, in order.
        for (int i = 0; i <= 16; i++) begin
            tick(1'b0, i < 16, mk(32'(4 * i), 1, 5'(i), 32'(i * 3)), 1'b1);
            if (i >= 1) begin
                tick_dummy_check(i);
            end
        end

        // Stall for three cycles while offering 0x200 then 0x204.
        tick(1'b0, 1'b1, mk(32'h200, 1, 1, 32'hA), 1'b0);
        tick(1'b0, 1'b1, mk(32'h204, 1, 2, 32'hB), 1'b0);
        accepted = (CAP == 2) ? accepted : 1'b0;
        tick(1'b0, !accepted && (CAP == 1), mk(32'h204, 1, 2, 32'hB), 1'b0);
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("stall_occ", 64'(occupancy_o), 2);
        chk("stall_in_ready", 64'(in_ready_o), 0);
`else
        chk("stall_occ", 64'(occupancy_o), 1);
        chk("stall_in_ready", 64'(in_ready_o), 0);
`endif
        chk("stall_pc", 64'(out_pc_o), 32'h200);
        guard = 0;
        got.delete();
        while (got.size() < 2 && guard < 10) begin
            tick(1'b0, (CAP == 1) && !(got.size() >= 1), mk(32'h204, 1, 2, 32'hB), 1'b1);
            if (seen_valid) got.push_back(int'(seen_pc));
            guard++;
        end
        chk("drain_count", 64'(got.size()), 2);
        if (got.size() == 2) begin
            chk("drain_first", 64'(got[0]), 32'h200);
            chk("drain_second", 64'(got[1]), 32'h204);
        end
        tick(1'b0, 1'b0, zp, 1'b1);

        // Asynchronous reset in mid-cycle with an entry held.
        tick(1'b0, 1'b1, mk(32'h600, 1, 4, 32'h77), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid_o), 0);
        chk("arst_wr_en", 64'(out_rd_wr_en_o), 0);
        chk("arst_pc", 64'(out_pc_o), 0);
        chk("arst_addr", 64'(out_rd_addr_o), 0);
        chk("arst_data", 64'(out_rd_data_o), 0);
        chk("arst_occ", 64'(occupancy_o), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            rp = mk($urandom, 1'($urandom), 5'($urandom), $urandom);
            tick(($urandom_range(15) == 0), ($urandom_range(9) < 7), rp, ($urandom_range(9) < 6));
        end

        chk("flushed_pc_never_seen", 64'(saw_300), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    task automatic tick_dummy_check(input int i);
        chk($sformatf("stream%0d_valid", i), 64'(seen_valid), 1);
        chk($sformatf("stream%0d_pc", i), 64'(seen_pc), 64'(4 * (i - 1)));
    endtask

endmodule
